operand_fetch: RTL and testbench

Read-side counterpart of the writeback path. It sits between decode and execute. Each cycle it reads up to two source operands from the register file's read ports, forwarding from the writeback port when the same register is being written that cycle. A 32-entry pending-write scoreboard stalls issue on RAW and WAW hazards until writeback clears the destination register. It presents a registered operand bundle to execute and holds it under back-pressure.

---
 rtl/operand_fetch.sv | 124 ++++++++++++
 tb/tb_operand_fetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage between decode and execute: reads two sources with
// writeback bypass, stalls on RAW/WAW via a pending-write scoreboard.
module operand_fetch #(
  parameter int DATA_WIDTH    = 32,
  parameter int PAYLOAD_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  // decode side
  input  logic                     id_of_valid,
  input  logic [4:0]               id_of_rs,
  input  logic [4:0]               id_of_rt,
  input  logic                     id_of_uses_rs,
  input  logic                     id_of_uses_rt,
  input  logic [4:0]               id_of_rd,
  input  logic                     id_of_writereg,
  input  logic [PAYLOAD_WIDTH-1:0] id_of_payload,
  output logic                     of_id_stall,
  // register file read ports
  output logic [4:0]               of_reg_addra,
  output logic [4:0]               of_reg_addrb,
  input  logic [DATA_WIDTH-1:0]    reg_of_dataa,
  input  logic [DATA_WIDTH-1:0]    reg_of_datab,
  // writeback port
  input  logic                     wb_reg_en,
  input  logic [4:0]               wb_reg_addr,
  input  logic [DATA_WIDTH-1:0]    wb_reg_data,
  // execute side
  output logic                     of_ex_valid,
  output logic [DATA_WIDTH-1:0]    of_ex_rsval,
  output logic [DATA_WIDTH-1:0]    of_ex_rtval,
  output logic [4:0]               of_ex_regdest,
  output logic                     of_ex_writereg,
  output logic [PAYLOAD_WIDTH-1:0] of_ex_payload,
  input  logic                     ex_of_stall,
  // scoreboard observation
  output logic [31:0]              dbg_pending
);

  // Handshakes: decode transfers when id_of_valid && !of_id_stall; execute
  // consumes the bundle when of_ex_valid && !ex_of_stall. A stalled producer
  // holds its inputs stable, and ex_of_stall means nothing while !of_ex_valid.

  logic [31:0]           pending;
  logic [31:0]           set_mask;
  logic [31:0]           clr_mask;
  logic [31:0]           pending_next;
  logic                  rs_ready;
  logic                  rt_ready;
  logic                  rd_ready;
  logic                  hazard;
  logic                  hold;
  logic                  issue;
  logic [DATA_WIDTH-1:0] rs_val;
  logic [DATA_WIDTH-1:0] rt_val;
  logic                  wb_hit_rs;
  logic                  wb_hit_rt;
  logic                  wb_hit_rd;

  assign of_reg_addra = id_of_rs;
  assign of_reg_addrb = id_of_rt;
  assign dbg_pending  = pending;

  assign wb_hit_rs = wb_reg_en && (wb_reg_addr == id_of_rs);
  assign wb_hit_rt = wb_reg_en && (wb_reg_addr == id_of_rt);
  assign wb_hit_rd = wb_reg_en && (wb_reg_addr == id_of_rd);

  // A writeback landing this cycle satisfies a waiting source via the bypass.
  assign rs_ready = (id_of_rs == 5'd0) || !id_of_uses_rs || !pending[id_of_rs] || wb_hit_rs;
  assign rt_ready = (id_of_rt == 5'd0) || !id_of_uses_rt || !pending[id_of_rt] || wb_hit_rt;
  assign rd_ready = !id_of_writereg || (id_of_rd == 5'd0) || !pending[id_of_rd] || wb_hit_rd;

  assign hazard      = id_of_valid && !(rs_ready && rt_ready && rd_ready);
  assign hold        = of_ex_valid && ex_of_stall;
  assign of_id_stall = hazard || hold;
  assign issue       = id_of_valid && !of_id_stall;

  always_comb begin
    rs_val = reg_of_dataa;
    if (id_of_rs == 5'd0) rs_val = '0;
    else if (wb_hit_rs)   rs_val = wb_reg_data;
  end

  always_comb begin
    rt_val = reg_of_datab;
    if (id_of_rt == 5'd0) rt_val = '0;
    else if (wb_hit_rt)   rt_val = wb_reg_data;
  end

  // Set is applied after clear so a same-register set/clear leaves it pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue && id_of_writereg && (id_of_rd != 5'd0)) set_mask[id_of_rd] = 1'b1;
    if (wb_reg_en && (wb_reg_addr != 5'd0))            clr_mask[wb_reg_addr] = 1'b1;
    pending_next    = (pending & ~clr_mask) | set_mask;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending        <= '0;
      of_ex_valid    <= 1'b0;
      of_ex_rsval    <= '0;
      of_ex_rtval    <= '0;
      of_ex_regdest  <= '0;
      of_ex_writereg <= 1'b0;
      of_ex_payload  <= '0;
    end else begin
      pending <= pending_next;
      if (issue) begin
        of_ex_valid    <= 1'b1;
        of_ex_rsval    <= rs_val;
        of_ex_rtval    <= rt_val;
        of_ex_regdest  <= id_of_rd;
        of_ex_writereg <= id_of_writereg;
        of_ex_payload  <= id_of_payload;
      end else if (!hold) begin
        of_ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed, table-driven bench for operand_fetch: per-cycle input records with
// hand-computed stall, output bundle and scoreboard expectations.
module tb_operand_fetch;

  localparam int DW = 32;
  localparam int PW = 32;
  localparam int NV = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic          id_of_valid;
  logic [4:0]    id_of_rs, id_of_rt, id_of_rd;
  logic          id_of_uses_rs, id_of_uses_rt, id_of_writereg;
  logic [PW-1:0] id_of_payload;
  logic          of_id_stall;
  logic [4:0]    of_reg_addra, of_reg_addrb;
  logic [DW-1:0] reg_of_dataa, reg_of_datab;
  logic          wb_reg_en;
  logic [4:0]    wb_reg_addr;
  logic [DW-1:0] wb_reg_data;
  logic          of_ex_valid;
  logic [DW-1:0] of_ex_rsval, of_ex_rtval;
  logic [4:0]    of_ex_regdest;
  logic          of_ex_writereg;
  logic [PW-1:0] of_ex_payload;
  logic          ex_of_stall;
  logic [31:0]   dbg_pending;

  int checks = 0;
  int errors = 0;

  operand_fetch #(.DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW)) dut (
    .clock(clock), .reset(reset),
    .id_of_valid(id_of_valid), .id_of_rs(id_of_rs), .id_of_rt(id_of_rt),
    .id_of_uses_rs(id_of_uses_rs), .id_of_uses_rt(id_of_uses_rt),
    .id_of_rd(id_of_rd), .id_of_writereg(id_of_writereg),
    .id_of_payload(id_of_payload), .of_id_stall(of_id_stall),
    .of_reg_addra(of_reg_addra), .of_reg_addrb(of_reg_addrb),
    .reg_of_dataa(reg_of_dataa), .reg_of_datab(reg_of_datab),
    .wb_reg_en(wb_reg_en), .wb_reg_addr(wb_reg_addr), .wb_reg_data(wb_reg_data),
    .of_ex_valid(of_ex_valid), .of_ex_rsval(of_ex_rsval), .of_ex_rtval(of_ex_rtval),
    .of_ex_regdest(of_ex_regdest), .of_ex_writereg(of_ex_writereg),
    .of_ex_payload(of_ex_payload), .ex_of_stall(ex_of_stall),
    .dbg_pending(dbg_pending)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt;
    logic        urs, urt;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] pl, da, db;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        exs;
    logic        e_stall, e_valid, chk;
    logic [31:0] e_rs, e_rt;
    logic [4:0]  e_rd;
    logic        e_wr;
    logic [31:0] e_pl, e_pend;
  } vec_t;

  vec_t vt[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_of_valid    = v.valid;
    id_of_rs       = v.rs;
    id_of_rt       = v.rt;
    id_of_uses_rs  = v.urs;
    id_of_uses_rt  = v.urt;
    id_of_rd       = v.rd;
    id_of_writereg = v.wr;
    id_of_payload  = v.pl;
    reg_of_dataa   = v.da;
    reg_of_datab   = v.db;
    wb_reg_en      = v.wbe;
    wb_reg_addr    = v.wba;
    wb_reg_data    = v.wbd;
    ex_of_stall    = v.exs;
  endtask

  // Drive one cycle's inputs, check the combinational stall, then the
  // registered bundle and scoreboard after the edge.
  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    drive(v);
    #1;
    check({tag, ".stall"}, {31'd0, of_id_stall}, {31'd0, v.e_stall});
    check({tag, ".addra"}, {27'd0, of_reg_addra}, {27'd0, v.rs});
    check({tag, ".addrb"}, {27'd0, of_reg_addrb}, {27'd0, v.rt});
    @(posedge clock);
    #1;
    check({tag, ".valid"}, {31'd0, of_ex_valid}, {31'd0, v.e_valid});
    if (v.chk) begin
      check({tag, ".rsval"}, of_ex_rsval, v.e_rs);
      check({tag, ".rtval"}, of_ex_rtval, v.e_rt);
      check({tag, ".regdest"}, {27'd0, of_ex_regdest}, {27'd0, v.e_rd});
      check({tag, ".writereg"}, {31'd0, of_ex_writereg}, {31'd0, v.e_wr});
      check({tag, ".payload"}, of_ex_payload, v.e_pl);
    end
    check({tag, ".pending"}, dbg_pending, v.e_pend);
  endtask

  initial begin
    //       vld rs    rt    urs  urt  rd    wr   pl         da         db         wbe  wba   wbd        exs  stl  val  chk  e_rs       e_rt       e_rd  e_wr e_pl       e_pend
    vt[0]  = '{1'b1, 5'd3,  5'd4,  1'b1, 1'b1, 5'd0,  1'b0, 32'h100, 32'd11,   32'd22,   1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b1, 1'b1, 32'd11,   32'd22,   5'd0,  1'b0, 32'h100, 32'h0};
    vt[1]  = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 32'h0,   32'd0,    32'd0,    1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b0, 1'b0, 32'd0,    32'd0,    5'd0,  1'b0, 32'h0,   32'h0};
    vt[2]  = '{1'b1, 5'd1,  5'd2,  1'b0, 1'b0, 5'd10, 1'b1, 32'h200, 32'd5,    32'd6,    1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b1, 1'b1, 32'd5,    32'd6,    5'd10, 1'b1, 32'h200, 32'h400};
    vt[3]  = '{1'b1, 5'd10, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 32'h300, 32'd0,    32'd0,    1'b0, 5'd0,  32'd0,   1'b0, 1'b1, 1'b0, 1'b0, 32'd0,    32'd0,    5'd0,  1'b0, 32'h0,   32'h400};
    vt[4]  = '{1'b1, 5'd10, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 32'h300, 32'd0,    32'd0,    1'b0, 5'd0,  32'd0,   1'b0, 1'b1, 1'b0, 1'b0, 32'd0,    32'd0,    5'd0,  1'b0, 32'h0,   32'h400};
    vt[5]  = '{1'b1, 5'd10, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 32'h300, 32'd0,    32'd0,    1'b1, 5'd10, 32'd37,  1'b0, 1'b0, 1'b1, 1'b1, 32'd37,   32'd0,    5'd0,  1'b0, 32'h300, 32'h0};
    vt[6]  = '{1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 32'h400, 32'd99,   32'd88,   1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b1, 1'b1, 32'd0,    32'd0,    5'd0,  1'b1, 32'h400, 32'h0};
    vt[7]  = '{1'b1, 5'd7,  5'd8,  1'b0, 1'b0, 5'd5,  1'b1, 32'h500, 32'd1,    32'd2,    1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b1, 1'b1, 32'd1,    32'd2,    5'd5,  1'b1, 32'h500, 32'h20};
    vt[8]  = '{1'b1, 5'd7,  5'd8,  1'b0, 1'b0, 5'd5,  1'b1, 32'h600, 32'd3,    32'd4,    1'b0, 5'd0,  32'd0,   1'b0, 1'b1, 1'b0, 1'b0, 32'd0,    32'd0,    5'd0,  1'b0, 32'h0,   32'h20};
    vt[9]  = '{1'b1, 5'd7,  5'd8,  1'b0, 1'b0, 5'd5,  1'b1, 32'h600, 32'd3,    32'd4,    1'b1, 5'd5,  32'd55,  1'b0, 1'b0, 1'b1, 1'b1, 32'd3,    32'd4,    5'd5,  1'b1, 32'h600, 32'h20};
    vt[10] = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 32'h0,   32'd0,    32'd0,    1'b1, 5'd5,  32'd0,   1'b0, 1'b0, 1'b0, 1'b0, 32'd0,    32'd0,    5'd0,  1'b0, 32'h0,   32'h0};
    vt[11] = '{1'b1, 5'd6,  5'd9,  1'b1, 1'b1, 5'd0,  1'b0, 32'h700, 32'd60,   32'd70,   1'b1, 5'd9,  32'd123, 1'b0, 1'b0, 1'b1, 1'b1, 32'd60,   32'd123,  5'd0,  1'b0, 32'h700, 32'h0};
    vt[12] = '{1'b1, 5'd12, 5'd13, 1'b1, 1'b1, 5'd14, 1'b1, 32'h800, 32'd1200, 32'd1300, 1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b1, 1'b1, 32'd1200, 32'd1300, 5'd14, 1'b1, 32'h800, 32'h4000};
    vt[13] = '{1'b1, 5'd12, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 32'h900, 32'd1200, 32'd0,    1'b1, 5'd12, 32'd90,  1'b1, 1'b1, 1'b1, 1'b1, 32'd1200, 32'd1300, 5'd14, 1'b1, 32'h800, 32'h4000};
    vt[14] = '{1'b1, 5'd12, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 32'h900, 32'd90,   32'd0,    1'b1, 5'd12, 32'd90,  1'b1, 1'b1, 1'b1, 1'b1, 32'd1200, 32'd1300, 5'd14, 1'b1, 32'h800, 32'h4000};
    vt[15] = '{1'b1, 5'd12, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 32'h900, 32'd90,   32'd0,    1'b1, 5'd12, 32'd90,  1'b1, 1'b1, 1'b1, 1'b1, 32'd1200, 32'd1300, 5'd14, 1'b1, 32'h800, 32'h4000};
    vt[16] = '{1'b1, 5'd12, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 32'h900, 32'd90,   32'd0,    1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b1, 1'b1, 32'd90,   32'd0,    5'd0,  1'b0, 32'h900, 32'h4000};
    vt[17] = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 32'h0,   32'd0,    32'd0,    1'b1, 5'd14, 32'd5,   1'b0, 1'b0, 1'b0, 1'b0, 32'd0,    32'd0,    5'd0,  1'b0, 32'h0,   32'h0};
    vt[18] = '{1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd0,  1'b0, 32'hA00, 32'd10,   32'd20,   1'b0, 5'd0,  32'd0,   1'b1, 1'b0, 1'b1, 1'b1, 32'd10,   32'd20,   5'd0,  1'b0, 32'hA00, 32'h0};
    vt[19] = '{1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd10, 1'b1, 32'hB00, 32'd11,   32'd21,   1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b1, 1'b1, 32'd11,   32'd21,   5'd10, 1'b1, 32'hB00, 32'h400};

    // reset with idle inputs
    reset = 1'b1;
    drive(vt[1]);
    repeat (2) @(posedge clock);
    #1;
    check("rst.valid", {31'd0, of_ex_valid}, 32'd0);
    check("rst.rsval", of_ex_rsval, 32'd0);
    check("rst.rtval", of_ex_rtval, 32'd0);
    check("rst.regdest", {27'd0, of_ex_regdest}, 32'd0);
    check("rst.writereg", {31'd0, of_ex_writereg}, 32'd0);
    check("rst.payload", of_ex_payload, 32'd0);
    check("rst.pending", dbg_pending, 32'd0);
    check("rst.stall", {31'd0, of_id_stall}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) apply(vt[i], i);

    // Reset while pending[10]=1 and the bundle is valid, with a competing
    // issue and writeback present: reset must win.
    drive(vt[2]);
    wb_reg_en   = 1'b1;
    wb_reg_addr = 5'd3;
    wb_reg_data = 32'd77;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst2.valid", {31'd0, of_ex_valid}, 32'd0);
    check("rst2.pending", dbg_pending, 32'd0);
    check("rst2.rsval", of_ex_rsval, 32'd0);
    check("rst2.regdest", {27'd0, of_ex_regdest}, 32'd0);
    check("rst2.payload", of_ex_payload, 32'd0);

    drive(vt[3]);
    reg_of_dataa = 32'd4242;
    #1;
    check("post_rst.stall", {31'd0, of_id_stall}, 32'd0);
    @(posedge clock);
    #1;
    check("post_rst.valid", {31'd0, of_ex_valid}, 32'd1);
    check("post_rst.rsval", of_ex_rsval, 32'd4242);
    check("post_rst.payload", of_ex_payload, 32'h300);

    drive(vt[1]);
    @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
